// File: rtl/mult_iter_16b.sv
//==============================================================================
// Module   : mult_iter_16b (with cla_16b)
// Purpose  : Iterative 16x16->32 shift-add multiplier driving one 16-bit CLA.
//            Optional signed mode when MULT_SIGNED_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cla_16b (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  cg;

  assign g = x & y;
  assign p = x ^ y;

  // Per-nibble lookahead: local carries from the group carry-in, plus group G/P.
  for (genvar i = 0; i < 4; i++) begin : g_grp
    logic [3:0] gl;
    logic [3:0] pl;
    assign gl = g[4*i +: 4];
    assign pl = p[4*i +: 4];

    assign c[4*i]     = cg[i];
    assign c[4*i + 1] = gl[0] | (pl[0] & cg[i]);
    assign c[4*i + 2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & cg[i]);
    assign c[4*i + 3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                      | (pl[2] & pl[1] & pl[0] & cg[i]);

    assign gg[i] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                 | (pl[3] & pl[2] & pl[1] & gl[0]);
    assign pg[i] = &pl;
  end

  assign cg[0] = cin;
  assign cg[1] = gg[0] | (pg[0] & cin);
  assign cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
  assign cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & cin);
  assign cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0])
               | (pg[3] & pg[2] & pg[1] & pg[0] & cin);

  assign sum  = p ^ c;
  assign cout = cg[4];

endmodule

module mult_iter_16b #(
  parameter int N     = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
`ifdef MULT_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     mcand;
  logic [N-1:0]     mplr;
  logic [N-1:0]     hi;
  logic             neg;

  logic             accept;
  logic [N-1:0]     add_op;
  logic [N-1:0]     sum_w;
  logic             carry_w;
  logic [2*N-1:0]   step_w;
  logic [2*N-1:0]   final_w;
  logic [N-1:0]     a_mag;
  logic [N-1:0]     b_mag;
  logic             neg_nxt;

  assign accept = start && (state != RUN);

`ifdef MULT_SIGNED_EN
  // Magnitudes of 0x8000 stay 0x8000, which is exact when read as unsigned.
  assign a_mag   = (signed_op && a[N-1]) ? (~a + 1'b1) : a;
  assign b_mag   = (signed_op && b[N-1]) ? (~b + 1'b1) : b;
  assign neg_nxt = signed_op && (a[N-1] ^ b[N-1]);
`else
  assign a_mag   = a;
  assign b_mag   = b;
  assign neg_nxt = 1'b0;
`endif

  assign add_op = mplr[0] ? mcand : '0;

  cla_16b u_cla (
    .x    (hi),
    .y    (add_op),
    .cin  (1'b0),
    .sum  (sum_w),
    .cout (carry_w)
  );

  // Lower 32 bits of the 33-bit {carry, sum, mplr} >> 1.
  assign step_w  = {carry_w, sum_w, mplr[N-1:1]};
  assign final_w = neg ? (~step_w + 1'b1) : step_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      hi      <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (accept) begin
      cnt   <= '0;
      mcand <= a_mag;
      mplr  <= b_mag;
      hi    <= '0;
      neg   <= neg_nxt;
    end else if (state == RUN) begin
      hi   <= step_w[2*N-1:N];
      mplr <= step_w[N-1:0];
      cnt  <= cnt + 1'b1;
      if (cnt == LAST_CNT) begin
        product <= final_w;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_iter_16b.sv
//==============================================================================
// Module   : tb_mult_iter_16b
// Purpose  : Randomized self-checking bench for mult_iter_16b against an
//            arithmetic reference; signed cases when MULT_SIGNED_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mult_iter_16b;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        signed_op = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_prod = '0;

  mult_iter_16b dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef MULT_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic sop);
    longint px;
    longint py;
    longint pr;
    px = sop ? longint'($signed(x)) : longint'(x);
    py = sop ? longint'($signed(y)) : longint'(y);
    pr = px * py;
    return pr[31:0];
  endfunction

  // Caller sits at a negedge (idle, or the done cycle of the previous op).
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sop,
                        input int repulse_at);
    logic [31:0] exp;
    int          n;
    int          nbusy;
    exp       = model(av, bv, sop);
    a         = av;
    b         = bv;
    signed_op = sop;
    start     = 1'b1;
    n         = 0;
    nbusy     = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) begin
        nbusy++;
        if (product !== last_prod) check("hold_in_run", product, last_prod);
      end
      if (n == repulse_at) begin
        a     = 16'd9;
        b     = 16'd9;
        start = 1'b1;
      end
    end while (!done && n < 60);
    check("latency", 32'(n), 32'd17);
    check("busy_cycles", 32'(nbusy), 32'd16);
    check("product", product, exp);
    last_prod = exp;
  endtask

  task automatic expect_idle_next();
    @(negedge clk);
    check("done_pulse_len", {31'b0, done}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int seen_done;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;

    // Reset and idle with no start.
    rst = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0)
        check("idle_quiet", {busy, done, 30'b0} | product, 32'd0);
    end
    check("idle_product", product, 32'd0);

    run_op(16'h00FF, 16'h0101, 1'b0, -1);
    expect_idle_next();
    run_op(16'hFFFF, 16'hFFFF, 1'b0, -1);
    expect_idle_next();

    // Mid-run start ignored, then back-to-back start from the done cycle.
    run_op(16'd3, 16'd5, 1'b0, 5);
    run_op(16'd7, 16'd9, 1'b0, -1);
    expect_idle_next();

    // Reset in the middle of a run.
    a     = 16'h1234;
    b     = 16'h5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_product", product, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    last_prod = '0;
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("no_done_after_abort", 32'(seen_done), 32'd0);
    run_op(16'd2, 16'd3, 1'b0, -1);
    expect_idle_next();

`ifdef MULT_SIGNED_EN
    run_op(16'hFFFD, 16'd7, 1'b1, -1);
    run_op(16'h8000, 16'h8000, 1'b1, -1);
    run_op(16'hFFFD, 16'd7, 1'b0, -1);
    expect_idle_next();
`endif

    // Random traffic with corner operands and mixed back-to-back / gapped issue.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 16'h0000;
        1:       ra = 16'hFFFF;
        2:       ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 16'h0000;
        1:       rb = 16'hFFFF;
        2:       rb = 16'h8000;
        default: rb = 16'($urandom);
      endcase
`ifdef MULT_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs, -1);
      if ($urandom_range(0, 1) == 0) begin
        expect_idle_next();
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
